// File: rtl/ecc_pkg.sv
// ---------------------------------------------------------------------------
// ecc_pkg
// Shared definitions for the serial modular subtractor:
//   state_e      - controller states (IDLE, SUB, CORR, DONE)
//   calc_ndig    - number of DIGIT-wide slices in a WIDTH-bit operand
//   calc_cnt_w   - width of a counter that spans 0..ndig-1 (at least 1 bit)
// ---------------------------------------------------------------------------
package ecc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        CORR = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic int calc_ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // A single-slice configuration still needs a one-bit counter.
    function automatic int calc_cnt_w(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/mod_sub_serial_if.sv
// ---------------------------------------------------------------------------
// mod_sub_serial_if
// Operand/result handshake bundle for mod_sub_serial.
//   in_valid / in_ready   - operand handshake (a, b, p)
//   a, b, p               - minuend, subtrahend, modulus (WIDTH bits)
//   out_valid / out_ready - result handshake
//   result                - (a - b) mod p
//   borrow                - raw borrow of a - b
// Modports: slave (the subtractor), master (the operand producer/consumer).
// ---------------------------------------------------------------------------
interface mod_sub_serial_if #(
    parameter int WIDTH = 256
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] p;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             borrow;

    modport slave (
        input  in_valid, a, b, p, out_ready,
        output in_ready, out_valid, result, borrow
    );

    modport master (
        output in_valid, a, b, p, out_ready,
        input  in_ready, out_valid, result, borrow
    );
endinterface

// File: rtl/mod_sub_serial_digit_addsub.sv
// ---------------------------------------------------------------------------
// digit_addsub
// One DIGIT-wide slice of a ripple add/subtract: {cout, s} = x + y' + cin,
// where y' = ~y when sub = 1 and y otherwise. Subtraction uses the
// inverted-borrow convention, so the caller seeds cin = 1 on the LSB slice.
//   x, y  - slice operands
//   cin   - carry in from the previous (less significant) slice
//   sub   - 1: invert y (subtract), 0: add
//   s     - slice sum
//   cout  - carry out to the next slice
// ---------------------------------------------------------------------------
module digit_addsub #(
    parameter int DIGIT = 32
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    logic [DIGIT-1:0] yEff;
    logic [DIGIT:0]   sum;

    // Conditional inversion of y followed by a carry-propagating add.
    always_comb begin
        yEff = sub ? ~y : y;
        sum  = {1'b0, x} + {1'b0, yEff} + {{DIGIT{1'b0}}, cin};
    end

    assign s    = sum[DIGIT-1:0];
    assign cout = sum[DIGIT];

endmodule

// File: rtl/mod_sub_serial.sv
// ---------------------------------------------------------------------------
// mod_sub_serial
// Digit-serial modular subtractor: result = (a - b) mod p, assuming a, b < p.
// Operands are captured on an accept, a - b is formed one DIGIT slice per
// cycle (LSB first), and p is then added back slice by slice when the
// subtraction borrowed. One digit_addsub slice is shared by both phases.
//
// Parameters:
//   WIDTH - operand/result width (must be a multiple of DIGIT)
//   DIGIT - bits processed per cycle
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   bus   - mod_sub_serial_if.slave (operand and result handshakes)
//
// Build option:
//   MOD_SUB_CONST_TIME_EN defined   - the correction pass always runs, so the
//                                     latency never depends on the data.
//   MOD_SUB_CONST_TIME_EN undefined - the correction pass is skipped when the
//                                     subtraction did not borrow.
// ---------------------------------------------------------------------------
module mod_sub_serial
    import ecc_pkg::*;
#(
    parameter int WIDTH = 256,
    parameter int DIGIT = 32
) (
    input logic                 clk,
    input logic                 rst,
    mod_sub_serial_if.slave     bus
);

    localparam int NDIG = calc_ndig(WIDTH, DIGIT);
    localparam int CNTW = calc_cnt_w(NDIG);
    localparam logic [CNTW-1:0] LAST_SLICE = CNTW'(NDIG - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNTW-1:0]  cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] acc_q;
    logic             carry_q;
    logic             borrow_q;

    logic             lastSlice;
    logic             inReady;
    logic             outValid;
    logic [DIGIT-1:0] sliceX;
    logic [DIGIT-1:0] sliceY;
    logic [DIGIT-1:0] sliceS;
    logic             sliceCin;
    logic             sliceSub;
    logic             sliceCout;

    // Shift a freshly computed slice into the top of the accumulator while
    // dropping the consumed LSB slice. After NDIG shifts the slices sit in
    // their natural positions.
    function automatic logic [WIDTH-1:0] shiftIn(input logic [WIDTH-1:0] acc,
                                                 input logic [DIGIT-1:0] s);
        logic [WIDTH+DIGIT-1:0] t;
        t = {s, acc};
        return t[WIDTH+DIGIT-1:DIGIT];
    endfunction

    assign lastSlice = (cnt_q == LAST_SLICE);

    // Operand routing into the shared slice adder. SUB consumes the LSB
    // slices of a and ~b; CORR adds the LSB slice of p (or zero) to the
    // partial difference that has already been shifted into acc_q.
    always_comb begin
        sliceX   = a_q[DIGIT-1:0];
        sliceY   = b_q[DIGIT-1:0];
        sliceSub = 1'b1;
        sliceCin = carry_q;
        if (state_q == CORR) begin
            sliceX   = acc_q[DIGIT-1:0];
            sliceY   = borrow_q ? p_q[DIGIT-1:0] : '0;
            sliceSub = 1'b0;
        end
    end

    digit_addsub #(
        .DIGIT (DIGIT)
    ) u_slice (
        .x    (sliceX),
        .y    (sliceY),
        .cin  (sliceCin),
        .sub  (sliceSub),
        .s    (sliceS),
        .cout (sliceCout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs. On the last SUB slice the final
    // borrow is the inverse of the slice carry; with no borrow the
    // correction pass can be skipped unless constant time is requested.
    always_comb begin
        state_d  = state_q;
        inReady  = 1'b0;
        outValid = 1'b0;
        case (state_q)
            IDLE: begin
                inReady = 1'b1;
                if (bus.in_valid) begin
                    state_d = SUB;
                end
            end
            SUB: begin
                if (lastSlice) begin
`ifdef MOD_SUB_CONST_TIME_EN
                    state_d = CORR;
`else
                    state_d = sliceCout ? DONE : CORR;
`endif
                end
            end
            CORR: begin
                if (lastSlice) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                outValid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath. The carry register holds the inverted borrow during SUB
    // (seeded to 1, i.e. borrow-in 0) and the ordinary carry during CORR
    // (seeded to 0). The carry out of the MSB in CORR is simply dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        p_q      <= bus.p;
                        cnt_q    <= '0;
                        carry_q  <= 1'b1;
                        borrow_q <= 1'b0;
                    end
                end
                SUB: begin
                    acc_q <= shiftIn(acc_q, sliceS);
                    a_q   <= a_q >> DIGIT;
                    b_q   <= b_q >> DIGIT;
                    if (lastSlice) begin
                        cnt_q    <= '0;
                        borrow_q <= ~sliceCout;
                        carry_q  <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q + CNTW'(1);
                        carry_q <= sliceCout;
                    end
                end
                CORR: begin
                    acc_q <= shiftIn(acc_q, sliceS);
                    p_q   <= p_q >> DIGIT;
                    if (lastSlice) begin
                        cnt_q   <= '0;
                        carry_q <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q + CNTW'(1);
                        carry_q <= sliceCout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid;
    assign bus.result    = acc_q;
    assign bus.borrow    = borrow_q;

endmodule

// File: tb/tb_mod_sub_serial.sv
// ---------------------------------------------------------------------------
// tb_mod_sub_serial
// Self-checking bench for mod_sub_serial at WIDTH=16, DIGIT=4.
// Expected results come from a plain-arithmetic model of (a - b) mod p and
// the expected latency from whether the subtraction borrows and whether
// MOD_SUB_CONST_TIME_EN is defined for this build.
// ---------------------------------------------------------------------------
module tb_mod_sub_serial;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int NDIG  = WIDTH / DIGIT;
    localparam logic [15:0] PVER = 16'hFFF1;
    localparam int LAT_B = 2 * NDIG + 1;
`ifdef MOD_SUB_CONST_TIME_EN
    localparam int LAT_NB = 2 * NDIG + 1;
`else
    localparam int LAT_NB = NDIG + 1;
`endif
    localparam int MAX_WAIT = 100;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic        bo;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mod_sub_serial_if #(.WIDTH(WIDTH)) bus();

    mod_sub_serial #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Compare one value and log a FAIL line when it differs.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: modular difference by signed integer arithmetic.
    function automatic void refModel(input logic [15:0] a, input logic [15:0] b,
                                     input logic [15:0] p, output logic [15:0] r,
                                     output logic bo, output int lat);
        int d;
        d  = int'({16'b0, a}) - int'({16'b0, b});
        bo = (a < b);
        if (d < 0) d = d + int'({16'b0, p});
        r   = d[15:0];
        lat = bo ? LAT_B : LAT_NB;
    endfunction

    // One full operation from IDLE: accept, wait for the result, stall the
    // consumer for 'stall' cycles, then hand the result off. Must be called
    // 1 time unit after a rising edge with the DUT idle.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] p, input int stall,
                                 input bit randReady, input string tag);
        logic [15:0] expR;
        logic        expBo;
        int          expLat;
        int          lat;
        refModel(a, b, p, expR, expBo, expLat);
        bus.a         = a;
        bus.b         = b;
        bus.p         = p;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a        = ~a;
        bus.b        = ~b;
        bus.p        = ~p;
        lat = 1;
        while (!bus.out_valid && lat < MAX_WAIT) begin
            if (randReady) bus.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        bus.out_ready = 1'b0;
        checkOutput({tag, ".latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, ".result"}, 32'(bus.result), 32'(expR));
        checkOutput({tag, ".borrow"}, 32'(bus.borrow), 32'(expBo));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            checkOutput({tag, ".stallValid"}, 32'(bus.out_valid), 32'(1));
            checkOutput({tag, ".stallResult"}, 32'(bus.result), 32'(expR));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checkOutput({tag, ".backToIdle"}, 32'({bus.in_ready, bus.out_valid}), 32'(2'b10));
    endtask

    // Overall time bound in case the DUT wedges somewhere unexpected.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[8];
        logic [15:0] rp;
        logic [15:0] ra;
        logic [15:0] rb;
        int          lat;

        vecs[0] = '{a: 16'h0005, b: 16'h0003, r: 16'h0002, bo: 1'b0};
        vecs[1] = '{a: 16'h0003, b: 16'h0005, r: 16'hFFEF, bo: 1'b1};
        vecs[2] = '{a: 16'h1234, b: 16'h1234, r: 16'h0000, bo: 1'b0};
        vecs[3] = '{a: 16'h0000, b: 16'hFFF0, r: 16'h0001, bo: 1'b1};
        vecs[4] = '{a: 16'hFFF0, b: 16'h0000, r: 16'hFFF0, bo: 1'b0};
        vecs[5] = '{a: 16'h0001, b: 16'hFFF0, r: 16'h0002, bo: 1'b1};
        vecs[6] = '{a: 16'hFFF0, b: 16'h0001, r: 16'hFFEF, bo: 1'b0};
        vecs[7] = '{a: 16'h0000, b: 16'h0000, r: 16'h0000, bo: 1'b0};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.p         = '0;

        // Reset values, observed before any clock edge.
        #1 rst = 1'b1;
        #2;
        checkOutput("reset.outValid", 32'(bus.out_valid), 32'(0));
        checkOutput("reset.inReady", 32'(bus.in_ready), 32'(1));
        checkOutput("reset.result", 32'(bus.result), 32'(0));
        checkOutput("reset.borrow", 32'(bus.borrow), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors with hand-derived expectations, full checks.
        for (int i = 0; i < 8; i++) begin
            bus.a        = vecs[i].a;
            bus.b        = vecs[i].b;
            bus.p        = PVER;
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            lat = 1;
            while (!bus.out_valid && lat < MAX_WAIT) begin
                @(posedge clk); #1;
                lat++;
            end
            checkOutput($sformatf("vec%0d.latency", i), 32'(lat),
                        32'(vecs[i].bo ? LAT_B : LAT_NB));
            checkOutput($sformatf("vec%0d.result", i), 32'(bus.result), 32'(vecs[i].r));
            checkOutput($sformatf("vec%0d.borrow", i), 32'(bus.borrow), 32'(vecs[i].bo));
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            checkOutput($sformatf("vec%0d.idle", i), 32'(bus.in_ready), 32'(1));
        end

        // Consumer stall: result held, new operands ignored, and no accept on
        // the cycle that returns to IDLE.
        bus.a        = 16'h0005;
        bus.b        = 16'h0003;
        bus.p        = PVER;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < MAX_WAIT) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("stall.latency", 32'(lat), 32'(LAT_NB));
        bus.a        = 16'h00AA;
        bus.b        = 16'h0011;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checkOutput("stall.outValid", 32'(bus.out_valid), 32'(1));
            checkOutput("stall.result", 32'(bus.result), 32'(16'h0002));
            checkOutput("stall.inReady", 32'(bus.in_ready), 32'(0));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        checkOutput("stall.release", 32'({bus.in_ready, bus.out_valid}), 32'(2'b10));
        @(posedge clk); #1;
        checkOutput("stall.noAccept", 32'(bus.in_ready), 32'(1));

        // Asynchronous reset in the middle of the subtraction pass.
        bus.a        = 16'h0003;
        bus.b        = 16'h0005;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        checkOutput("midReset.outValid", 32'(bus.out_valid), 32'(0));
        checkOutput("midReset.inReady", 32'(bus.in_ready), 32'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("midReset.stillIdle", 32'({bus.in_ready, bus.out_valid}), 32'(2'b10));
        applyStimulus(16'h0007, 16'h0009, PVER, 2, 1'b0, "afterReset");

        // Randomised operations with random moduli and consumer stalls.
        for (int n = 0; n < 1000; n++) begin
            rp = 16'($urandom_range(2, 65535));
            ra = 16'($urandom_range(0, int'({16'b0, rp}) - 1));
            rb = 16'($urandom_range(0, int'({16'b0, rp}) - 1));
            applyStimulus(ra, rb, rp, int'($urandom_range(0, 3)), 1'b1, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mod_sub_serial.md
MOD_SUB_SERIAL -- requirements
Module: mod_sub_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 256: operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 32: bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT; NDIG = WIDTH/DIGIT.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1: operands a, b, p are valid.
REQ-006 SHALL have port in_ready, output, 1: block accepts operands.
REQ-007 SHALL have ports a, b, p, input, WIDTH each: minuend, subtrahend and modulus.
REQ-008 SHALL have port out_valid, output, 1: result is valid.
REQ-009 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-010 SHALL have port result, output, WIDTH: (a - b) mod p.
REQ-011 SHALL have port borrow, output, 1: raw borrow of a - b (1 when a < b).

Function
REQ-012 SHALL implement FSM states IDLE, SUB, CORR and DONE; in_ready = 1 only in IDLE.
REQ-013 SHALL capture a, b and p on an accept cycle (in_valid && in_ready, cycle 0) and then move to SUB with digit counter 0 and borrow-in 0.
REQ-014 SHALL process one DIGIT slice per SUB cycle, LSB slice first, and compute diff = a + ~b + 1 by carrying the inverted borrow between slices; after NDIG cycles the final borrow SHALL equal NOT(carry out).
REQ-015 SHALL enter CORR after the last SUB slice; CORR SHALL add p (if borrow = 1) or 0 (if borrow = 0) to diff, one slice per cycle over NDIG cycles, LSB first, discarding the carry out of the MSB.
REQ-016 SHALL enter DONE after CORR with out_valid = 1 and hold result and borrow stable until out_valid && out_ready; it SHALL then return to IDLE.
REQ-017 SHALL keep the digit counter in the range 0..NDIG-1 and SHALL wrap it to 0 at each SUB->CORR and CORR->DONE transition.
REQ-018 Precondition: a < p and b < p; result SHALL then lie in 0..p-1. Behaviour outside the precondition is undefined apart from the wrap-around specified in REQ-015.
REQ-019 SHALL ignore in_valid while not in IDLE; operands presented then SHALL NOT be captured.
REQ-020 SHALL NOT let out_ready affect state outside DONE.
REQ-021 Maximum throughput SHALL be one operation per (latency + 1) cycles; there SHALL be no accept in the same cycle as the DONE->IDLE transition.

Reset
REQ-022 On rst = 1, the block SHALL enter IDLE at once, regardless of clk; out_valid = 0, result = 0, borrow = 0, digit counter = 0, in_ready = 1.
REQ-023 A reset during SUB, CORR or DONE SHALL abandon the operation without asserting out_valid.

Configuration
REQ-024 Macro MOD_SUB_CONST_TIME_EN defined: CORR SHALL always run (adding p or 0), and out_valid SHALL rise at cycle 2*NDIG+1 after accept, independent of the data.
REQ-025 Macro MOD_SUB_CONST_TIME_EN undefined: when borrow = 0, the block SHALL skip CORR and out_valid SHALL rise at cycle NDIG+1; when borrow = 1, the timing SHALL be as in REQ-024.

Structure
REQ-026 The FSM state enum and the NDIG/counter-width derivation SHALL live in the shared package ecc_pkg.
REQ-027 The slice arithmetic SHALL be one sub-module, digit_addsub (DIGIT-wide, inputs x, y, cin, sub; outputs s, cout), instantiated once and shared by SUB and CORR.

Verification (WIDTH=16, DIGIT=4, NDIG=4, p=0xFFF1)
REQ-028 a=0x0005, b=0x0003 -> result 0x0002, borrow 0; out_valid at cycle 9 with the macro, cycle 5 without.
REQ-029 a=0x0003, b=0x0005 -> result 0xFFEF, borrow 1; out_valid at cycle 9 in both builds.
REQ-030 a=b=0x1234 -> result 0x0000, borrow 0; a=0x0000, b=0xFFF0 -> result 0x0001, borrow 1.
REQ-031 out_ready held low 10 cycles in DONE -> result/out_valid stable, in_ready 0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-032 rst pulsed mid-SUB (cycle 2) -> out_valid 0, in_ready 1 immediately; next operation a=7, b=9 -> result 0xFFEF.
REQ-033 1000 random operations with a, b < p and random out_ready stalls -> every result equals (a-b) mod p, borrow equals (a<b).
